// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the program-counter sequencer and the control decoder.
package pc_sequencer_pkg;

    localparam logic [1:0] PCSEL_SEQ  = 2'b00;
    localparam logic [1:0] PCSEL_BR   = 2'b01;
    localparam logic [1:0] PCSEL_JALR = 2'b10;
    localparam logic [1:0] PCSEL_TRAP = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

endpackage

// File: rtl/pc_sequencer_next_calc.sv
// Next-PC target adder/mux with misaligned-target detection.
module pc_next_calc
    import pc_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [1:0]      i_pc_sel,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1,
    output logic [XLEN-1:0] o_target,
    output logic            o_misaligned
);

    logic [XLEN-1:0] w_jalr_sum;

    assign w_jalr_sum = i_rs1 + i_imm;

    // Select the redirect target; the trap encoding has no meaningful target.
    always_comb begin
        o_target     = i_pc + XLEN'(3'd4);
        o_misaligned = 1'b0;
        case (i_pc_sel)
            PCSEL_SEQ: begin
                o_target = i_pc + XLEN'(3'd4);
            end
            PCSEL_BR: begin
                o_target = i_pc + i_imm;
            end
            PCSEL_JALR: begin
                o_target = {w_jalr_sum[XLEN-1:1], 1'b0};
            end
            default: begin
                o_target = i_pc + XLEN'(3'd4);
            end
        endcase
        if (i_pc_sel != PCSEL_TRAP) begin
            o_misaligned = (o_target[1:0] != 2'b00);
        end else begin
            o_misaligned = 1'b0;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: redirect, stall, trap entry with EPC capture, and cycle/instret counters.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              ADDR_WIDTH   = 8,
    parameter int              CNT_WIDTH    = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0080
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic [1:0]            i_pc_sel,
    input  logic [XLEN-1:0]       i_imm,
    input  logic [XLEN-1:0]       i_rs1,
    output logic [XLEN-1:0]       o_pc,
    output logic [XLEN-1:0]       o_pc_plus4,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic                  o_fetch_valid,
    output logic                  o_trap,
    output logic [XLEN-1:0]       o_epc,
    output logic [CNT_WIDTH-1:0]  o_cycle_cnt,
    output logic [CNT_WIDTH-1:0]  o_instret_cnt
);

    state_e                r_state;
    logic [XLEN-1:0]       r_pc;
    logic [XLEN-1:0]       r_epc;
    logic                  r_trap;
    logic                  r_fetch_valid;
    logic [CNT_WIDTH-1:0]  r_cycle_cnt;
    logic [CNT_WIDTH-1:0]  r_instret_cnt;

    state_e                w_state_nxt;
    logic [XLEN-1:0]       w_pc_nxt;
    logic [XLEN-1:0]       w_epc_nxt;
    logic [XLEN-1:0]       w_target;
    logic                  w_misaligned;
    logic                  w_take_trap;
    logic                  w_retire;

    pc_next_calc #(.XLEN(XLEN)) u_next_calc (
        .i_pc         (r_pc),
        .i_pc_sel     (i_pc_sel),
        .i_imm        (i_imm),
        .i_rs1        (i_rs1),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    // Stall masks both explicit traps and misalignment.
    assign w_take_trap = (r_state == ST_RUN) && !i_stall &&
                         ((i_pc_sel == PCSEL_TRAP) || w_misaligned);
    assign w_retire    = (r_state == ST_RUN) && r_fetch_valid && !i_stall && !w_take_trap;

    // Next-state, next-PC and EPC selection.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
        case (r_state)
            ST_RUN: begin
                if (i_stall) begin
                    w_state_nxt = ST_RUN;
                end else if (w_take_trap) begin
                    w_state_nxt = ST_TRAP;
                    w_pc_nxt    = TRAP_VECTOR;
                    w_epc_nxt   = r_pc;
                end else begin
                    w_pc_nxt    = w_target;
                end
            end
            ST_TRAP: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State, PC, status and counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_VECTOR;
            r_epc         <= '0;
            r_trap        <= 1'b0;
            r_fetch_valid <= 1'b1;
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_epc         <= w_epc_nxt;
            r_trap        <= (w_state_nxt == ST_TRAP);
            r_fetch_valid <= (w_state_nxt == ST_RUN);
            r_cycle_cnt   <= r_cycle_cnt + CNT_WIDTH'(1'b1);
            if (w_retire) begin
                r_instret_cnt <= r_instret_cnt + CNT_WIDTH'(1'b1);
            end else begin
                r_instret_cnt <= r_instret_cnt;
            end
        end
    end

    assign o_pc          = r_pc;
    assign o_pc_plus4    = r_pc + XLEN'(3'd4);
    assign o_imem_addr   = r_pc[ADDR_WIDTH+1:2];
    assign o_fetch_valid = r_fetch_valid;
    assign o_trap        = r_trap;
    assign o_epc         = r_epc;
    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_instret_cnt = r_instret_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed steps push expected state, a negedge monitor compares.
module tb_pc_sequencer;

    localparam int XLEN = 32;
    localparam int AW   = 8;
    localparam int CW   = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall;
    logic [1:0]      pc_sel;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [AW-1:0]   imem_addr;
    logic            fetch_valid;
    logic            trap;
    logic [XLEN-1:0] epc;
    logic [CW-1:0]   cycle_cnt;
    logic [CW-1:0]   instret_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        trap;
        logic [7:0]  cyc;
        logic [7:0]  ins;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  e_cyc = 8'd0;
    logic [7:0]  e_ins = 8'd0;
    logic [31:0] lp_pc;

    pc_sequencer #(
        .XLEN(XLEN), .ADDR_WIDTH(AW), .CNT_WIDTH(CW),
        .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0080)
    ) u_dut (
        .i_clk(clk), .i_rst(rst_n), .i_stall(stall), .i_pc_sel(pc_sel),
        .i_imm(imm), .i_rs1(rs1), .o_pc(pc), .o_pc_plus4(pc_plus4),
        .o_imem_addr(imem_addr), .o_fetch_valid(fetch_valid), .o_trap(trap),
        .o_epc(epc), .o_cycle_cnt(cycle_cnt), .o_instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    // Monitor: one expected record per clock edge, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] e_p4;
            e    = exp_q.pop_front();
            e_p4 = e.pc + 32'd4;
            chk("pc",          pc,                   e.pc);
            chk("pc_plus4",    pc_plus4,             e_p4);
            chk("imem_addr",   {24'd0, imem_addr},   {24'd0, e.pc[9:2]});
            chk("trap",        {31'd0, trap},        {31'd0, e.trap});
            chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, ~e.trap});
            chk("epc",         epc,                  e.epc);
            chk("cycle_cnt",   {24'd0, cycle_cnt},   {24'd0, e.cyc});
            chk("instret_cnt", {24'd0, instret_cnt}, {24'd0, e.ins});
        end
    end

    task automatic step(input logic r, input logic s, input logic [1:0] sel,
                        input logic [31:0] im, input logic [31:0] rr,
                        input logic [31:0] x_pc, input logic [31:0] x_epc,
                        input logic x_trap, input logic retire);
        exp_t e;
        rst_n = r; stall = s; pc_sel = sel; imm = im; rs1 = rr;
        @(posedge clk);
        if (!r) begin
            e_cyc = 8'd0;
            e_ins = 8'd0;
        end else begin
            e_cyc = e_cyc + 8'd1;
            e_ins = e_ins + {7'd0, retire};
        end
        e.pc = x_pc; e.epc = x_epc; e.trap = x_trap; e.cyc = e_cyc; e.ins = e_ins;
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; pc_sel = 2'b00; imm = 32'd0; rs1 = 32'd0;
        step(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'b11, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        // Sequential fetch
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'h4, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'h8, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'hC, 32'h0, 1'b0, 1'b1);
        // JALR with odd sum lands at 8, then branches forward/back
        step(1'b1, 1'b0, 2'b10, 32'd0, 32'h9, 32'h8, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'b01, 32'h10, 32'd0, 32'h18, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'b01, 32'hFFFF_FFF0, 32'd0, 32'h08, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'b10, 32'd0, 32'h41, 32'h40, 32'h0, 1'b0, 1'b1);
        // Misaligned JALR traps; TRAP returns even under stall
        step(1'b1, 1'b0, 2'b10, 32'd0, 32'h42, 32'h80, 32'h40, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'b11, 32'd0, 32'd0, 32'h80, 32'h40, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'h84, 32'h40, 1'b0, 1'b1);
        // Misaligned branch
        step(1'b1, 1'b0, 2'b01, 32'h2, 32'd0, 32'h80, 32'h84, 1'b1, 1'b0);
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'h80, 32'h84, 1'b0, 1'b0);
        // Stall beats explicit trap
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 2'b11, 32'd0, 32'd0, 32'h80, 32'h84, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'b11, 32'd0, 32'd0, 32'h80, 32'h80, 1'b1, 1'b0);
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'h80, 32'h80, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'h84, 32'h80, 1'b0, 1'b1);
        // Stalled misaligned JALR is ignored
        step(1'b1, 1'b1, 2'b10, 32'd0, 32'h3, 32'h84, 32'h80, 1'b0, 1'b0);
        // PC wrap at top of address space
        step(1'b1, 1'b0, 2'b01, 32'hFFFF_FF78, 32'd0, 32'hFFFF_FFFC, 32'h80, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'h0, 32'h80, 1'b0, 1'b1);
        // Long sequential run: counters wrap, imem_addr aliases past 0x3FC
        lp_pc = 32'h0;
        for (int i = 0; i < 260; i++) begin
            lp_pc = lp_pc + 32'd4;
            step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, lp_pc, 32'h80, 1'b0, 1'b1);
        end
        // Reset during the TRAP cycle
        step(1'b1, 1'b0, 2'b11, 32'd0, 32'd0, 32'h80, lp_pc, 1'b1, 1'b0);
        step(1'b0, 1'b0, 2'b11, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'h4, 32'h0, 1'b0, 1'b1);
        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
